// File: rtl/gf_pkg.sv
// Shared definitions for the guided-filter stages: FSM encoding, frame
// defaults, the fixed-point fraction width of `a`, and signed saturation.
package gf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } gf_state_e;

  localparam int GF_IMG_W   = 300;
  localparam int GF_IMG_H   = 210;
  localparam int GF_A_SHIFT = 7;

  // Working width for saturation; wide enough for a full 2*DW+1 difference.
  localparam int GF_SAT_IW  = 64;

  function automatic logic signed [GF_SAT_IW-1:0] sat_signed(
    input logic signed [GF_SAT_IW-1:0] x,
    input int unsigned                 dw
  );
    logic signed [GF_SAT_IW-1:0] hi;
    logic signed [GF_SAT_IW-1:0] lo;
    hi = $signed((GF_SAT_IW'(1) << (dw - 1)) - GF_SAT_IW'(1));
    lo = ~hi;
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/gf_mulsub_pipe.sv
// Read-latency alignment plus the two-stage b = mean_p - ((a*mean_I) >> A_SHIFT)
// datapath with saturation, carrying a valid bit and address per word.
module gf_mulsub_pipe
  import gf_pkg::*;
#(
  parameter int DW      = 24,
  parameter int AW      = 16,
  parameter int A_SHIFT = GF_A_SHIFT,
  parameter int RD_LAT  = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vld_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_a_i,
  input  logic [DW-1:0] mean_i_i,
  input  logic [DW-1:0] mean_p_i,
  output logic          pending_o,
  output logic          wren_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] data_b_o
);

  logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [AW-1:0]     rd_addr_q [RD_LAT];
  logic [AW-1:0]     rd_addr_d [RD_LAT];

  logic              p1_vld_q,  p1_vld_d;
  logic [2*DW-1:0]   prod_q,    prod_d;
  logic [DW-1:0]     meanp_q,   meanp_d;
  logic [AW-1:0]     p1_addr_q, p1_addr_d;

  logic              wren_q,    wren_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DW-1:0]     data_b_q,  data_b_d;

  logic [2*DW-1:0]       shifted;
  logic signed [2*DW:0]  diff;
  logic signed [GF_SAT_IW-1:0] sat_in;

  always_comb begin
    rd_vld_d[0]  = vld_i;
    rd_addr_d[0] = addr_i;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i]  = rd_vld_q[i-1];
      rd_addr_d[i] = rd_addr_q[i-1];
    end
  end

  always_comb begin
    p1_vld_d  = rd_vld_q[RD_LAT-1];
    prod_d    = prod_q;
    meanp_d   = meanp_q;
    p1_addr_d = p1_addr_q;
    if (rd_vld_q[RD_LAT-1]) begin
      prod_d    = (2*DW)'(data_a_i) * (2*DW)'(mean_i_i);
      meanp_d   = mean_p_i;
      p1_addr_d = rd_addr_q[RD_LAT-1];
    end
  end

  // The subtraction is kept at full product width so that a huge shifted
  // product clamps to the negative limit instead of wrapping.
  always_comb begin
    shifted   = prod_q >> A_SHIFT;
    diff      = $signed({1'b0, {DW{1'b0}}, meanp_q}) - $signed({1'b0, shifted});
    sat_in    = {{(GF_SAT_IW-2*DW-1){diff[2*DW]}}, diff};
    wren_d    = p1_vld_q;
    wr_addr_d = wr_addr_q;
    data_b_d  = data_b_q;
    if (p1_vld_q) begin
      wr_addr_d = p1_addr_q;
      data_b_d  = DW'(sat_signed(sat_in, DW));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) rd_addr_q[i] <= '0;
      p1_vld_q  <= 1'b0;
      prod_q    <= '0;
      meanp_q   <= '0;
      p1_addr_q <= '0;
      wren_q    <= 1'b0;
      wr_addr_q <= '0;
      data_b_q  <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
      for (int unsigned i = 0; i < RD_LAT; i++) rd_addr_q[i] <= rd_addr_d[i];
      p1_vld_q  <= p1_vld_d;
      prod_q    <= prod_d;
      meanp_q   <= meanp_d;
      p1_addr_q <= p1_addr_d;
      wren_q    <= wren_d;
      wr_addr_q <= wr_addr_d;
      data_b_q  <= data_b_d;
    end
  end

  // The final stage is excluded so DONE lands the cycle after the last write.
  assign pending_o = (|rd_vld_q) | p1_vld_q;
  assign wren_o    = wren_q;
  assign wr_addr_o = wr_addr_q;
  assign data_b_o  = data_b_q;

endmodule

// File: rtl/calcu_b.sv
// Guided-filter b stage: sequences one read address per cycle over the frame
// and hands the words to the multiply/subtract pipeline that writes b.
module calcu_b
  import gf_pkg::*;
#(
  parameter int IMG_W   = GF_IMG_W,
  parameter int IMG_H   = GF_IMG_H,
  parameter int DW      = 24,
  parameter int AW      = 16,
  parameter int A_SHIFT = GF_A_SHIFT,
  parameter int RD_LAT  = 1
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          ena,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] oRdAddr,
  input  logic [DW-1:0] iDataA,
  input  logic [DW-1:0] iMeanI,
  input  logic [DW-1:0] iMeanP,
  output logic          oWren,
  output logic [AW-1:0] oWrAddr,
  output logic [DW-1:0] oDataB
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

  gf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q,   cnt_d;
  logic          issue;
  logic          pending;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ena) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST_ADDR) state_d = ST_DRAIN;
        else                    cnt_d   = cnt_q + AW'(1);
      end
      ST_DRAIN: begin
        if (!pending) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign issue   = (state_q == ST_RUN);
  assign oRdAddr = issue ? cnt_q : '0;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

  gf_mulsub_pipe #(
    .DW      (DW),
    .AW      (AW),
    .A_SHIFT (A_SHIFT),
    .RD_LAT  (RD_LAT)
  ) u_pipe (
    .clk_i     (iCLK),
    .rst_i     (iRST),
    .vld_i     (issue),
    .addr_i    (cnt_q),
    .data_a_i  (iDataA),
    .mean_i_i  (iMeanI),
    .mean_p_i  (iMeanP),
    .pending_o (pending),
    .wren_o    (oWren),
    .wr_addr_o (oWrAddr),
    .data_b_o  (oDataB)
  );

endmodule

// File: tb/tb_calcu_b.sv
// Directed bench for calcu_b on a 4x2 frame with a 1-cycle-latency RAM model.
module tb_calcu_b;

  localparam int DW = 24;
  localparam int AW = 16;
  localparam int NPIX = 8;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          ena;
  logic          done;
  logic          busy;
  logic [AW-1:0] oRdAddr;
  logic [DW-1:0] iDataA, iMeanI, iMeanP;
  logic          oWren;
  logic [AW-1:0] oWrAddr;
  logic [DW-1:0] oDataB;

  logic [DW-1:0] memA [NPIX];
  logic [DW-1:0] memI [NPIX];
  logic [DW-1:0] memP [NPIX];
  logic [DW-1:0] expB [NPIX];

  int checks = 0;
  int errors = 0;

  calcu_b #(
    .IMG_W   (4),
    .IMG_H   (2),
    .DW      (DW),
    .AW      (AW),
    .A_SHIFT (7),
    .RD_LAT  (1)
  ) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .ena     (ena),
    .done    (done),
    .busy    (busy),
    .oRdAddr (oRdAddr),
    .iDataA  (iDataA),
    .iMeanI  (iMeanI),
    .iMeanP  (iMeanP),
    .oWren   (oWren),
    .oWrAddr (oWrAddr),
    .oDataB  (oDataB)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) begin
    iDataA <= memA[oRdAddr[2:0]];
    iMeanI <= memI[oRdAddr[2:0]];
    iMeanP <= memP[oRdAddr[2:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic fill_uniform(input logic [DW-1:0] a, input logic [DW-1:0] mi,
                              input logic [DW-1:0] mp, input logic [DW-1:0] b);
    for (int k = 0; k < NPIX; k++) begin
      memA[k] = a; memI[k] = mi; memP[k] = mp; expB[k] = b;
    end
  endtask

  task automatic set_word(input int k, input logic [DW-1:0] a, input logic [DW-1:0] mi,
                          input logic [DW-1:0] mp, input logic [DW-1:0] b);
    memA[k] = a; memI[k] = mi; memP[k] = mp; expB[k] = b;
  endtask

  // Called at a sample point with the DUT idle; returns one cycle after done.
  task automatic run_frame(input string tag, input bit ena_mid, input bit ena_done);
    int nwr = 0;
    int first = -1;
    int done_cyc = -1;
    ena = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      ena = 1'b0;
      if (ena_mid && c == 5) ena = 1'b1;
      if (c == 1) check({tag, " busy@1"}, {63'd0, busy}, 64'd1);
      if (oWren) begin
        if (first < 0) first = c;
        check({tag, " wr_busy"}, {63'd0, busy}, 64'd1);
        check({tag, " wr_addr"}, {48'd0, oWrAddr}, nwr);
        if (nwr < NPIX) check({tag, " wr_data"}, {40'd0, oDataB}, {40'd0, expB[nwr]});
        nwr++;
      end
      if (done) begin
        done_cyc = c;
        if (ena_done) ena = 1'b1;
        break;
      end
    end
    check({tag, " first_wr_cycle"}, first, 4);
    check({tag, " done_cycle"}, done_cyc, 12);
    check({tag, " num_writes"}, nwr, NPIX);
    tick();
    ena = 1'b0;
  endtask

  initial begin
    int nw;
    int nd;
    int found;
    iRST = 1'b1;
    ena  = 1'b0;
    fill_uniform(24'd0, 24'd0, 24'd0, 24'd0);

    repeat (3) tick();
    check("rst done",    {63'd0, done},    0);
    check("rst busy",    {63'd0, busy},    0);
    check("rst oWren",   {63'd0, oWren},   0);
    check("rst oRdAddr", {48'd0, oRdAddr}, 0);
    check("rst oWrAddr", {48'd0, oWrAddr}, 0);
    check("rst oDataB",  {40'd0, oDataB},  0);

    iRST = 1'b0;
    nw = 0;
    repeat (20) begin
      tick();
      if (oWren || busy) nw++;
    end
    check("idle activity", nw, 0);

    fill_uniform(24'd128, 24'd100, 24'd100, 24'd0);
    run_frame("unity", 1'b0, 1'b0);

    // Starts in the cycle after done; also re-pulses ena mid-frame and in done.
    fill_uniform(24'd64, 24'd200, 24'd50, 24'hFFFFCE);
    run_frame("neg_b", 1'b1, 1'b1);
    check("ena_in_done busy@13", {63'd0, busy}, 0);
    tick();
    check("ena_in_done busy@14", {63'd0, busy}, 0);
    nw = 0;
    repeat (20) begin
      tick();
      if (oWren) nw++;
    end
    check("ena_in_done no writes", nw, 0);

    fill_uniform(24'd0, 24'd77, 24'd255, 24'd255);
    run_frame("pos_b", 1'b0, 1'b0);

    fill_uniform(24'hFFFFFF, 24'hFFFFFF, 24'd0, 24'h800000);
    run_frame("sat_neg", 1'b0, 1'b0);

    fill_uniform(24'd0, 24'd0, 24'hFFFFFF, 24'h7FFFFF);
    run_frame("sat_pos", 1'b0, 1'b0);

    set_word(0, 24'd128, 24'd0,    24'd10,      24'd10);
    set_word(1, 24'd1,   24'd255,  24'd10,      24'd9);
    set_word(2, 24'd1,   24'd127,  24'd10,      24'd10);
    set_word(3, 24'd256, 24'd50,   24'd0,       24'hFFFF9C);
    set_word(4, 24'd64,  24'd3,    24'd5,       24'd4);
    set_word(5, 24'd0,   24'd0,    24'd0,       24'd0);
    set_word(6, 24'd200, 24'd100,  24'h7FFFFF,  24'h7FFF63);
    set_word(7, 24'd128, 24'd1000, 24'd0,       24'hFFFC18);
    run_frame("mixed", 1'b0, 1'b0);

    ena = 1'b1;
    found = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      ena = 1'b0;
      if (busy && oRdAddr == 16'd3) begin
        found = 1;
        break;
      end
    end
    check("midrst reached addr3", found, 1);
    iRST = 1'b1;
    tick();
    check("midrst oWren", {63'd0, oWren}, 0);
    check("midrst busy",  {63'd0, busy},  0);
    check("midrst done",  {63'd0, done},  0);
    iRST = 1'b0;
    nw = 0;
    nd = 0;
    repeat (20) begin
      tick();
      if (oWren) nw++;
      if (done) nd++;
    end
    check("midrst no writes", nw, 0);
    check("midrst no done",   nd, 0);
    run_frame("after_rst", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
